// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter that shares one UART
// transmitter among NUM_REQ byte streams. A requester keeps the grant from its
// first byte until its last byte has left the UART.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, an owner that stalls (valid low while holding the grant) for
//   TIMEOUT_CYC cycles loses the grant and oTimeout pulses for one cycle.
//   When undefined, the grant is held indefinitely and oTimeout is tied low.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no owner; scan requesters starting at the round-robin pointer
// LOAD  | owner granted; waiting for its next byte and for the UART to be ready
// WAIT  | byte handed to the UART; holding data until the frame completes

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NUM_REQ-1:0]        iReq_Val,
  input  logic [NUM_REQ*DATA_W-1:0] iReq_Data,
  input  logic [NUM_REQ-1:0]        iReq_Last,
  output logic [NUM_REQ-1:0]        oReq_Rdy,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic                      oTx_Val,
  output logic [DATA_W-1:0]         oTx_Data,
  input  logic                      iTx_Rdy,
  input  logic                      iTx_done,
  output logic                      oBusy,
  output logic                      oTimeout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t stateQ, stateD;

  logic [PTR_W-1:0]  ptrQ;
  logic [PTR_W-1:0]  ownerQ;
  logic [PTR_W-1:0]  pickIdx;
  logic [PTR_W-1:0]  nextPtr;
  logic              anyReq;
  logic              ownVal;
  logic              xfer;
  logic              doneHit;
  logic              lastQ;
  logic              txValQ;
  logic              tmoHit;
  logic [DATA_W-1:0] dataQ;
  logic [DATA_W-1:0] ownData;

  if (NUM_REQ < 1 || NUM_REQ > 16 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : gBadParam
    $error("uart_tx_arbiter: parameter out of range");
  end

  assign ownVal  = iReq_Val[ownerQ];
  assign ownData = iReq_Data[ownerQ*DATA_W +: DATA_W];
  assign xfer    = (stateQ == LOAD) && ownVal && iTx_Rdy;
  assign doneHit = (stateQ == WAIT) && iTx_done;
  assign nextPtr = (ownerQ == PTR_W'(NUM_REQ - 1)) ? '0 : ownerQ + 1'b1;

  // Round-robin scan: first valid requester at or after the pointer, wrapping.
  always_comb begin
    anyReq  = 1'b0;
    pickIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!anyReq && iReq_Val[(int'(ptrQ) + i) % NUM_REQ]) begin
        anyReq  = 1'b1;
        pickIdx = PTR_W'((int'(ptrQ) + i) % NUM_REQ);
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tmoCnt;
  logic             timeoutQ;

  // Stall-limit down-counter; terminal count reached while the owner is still idle aborts the grant.
  assign tmoHit = (stateQ == LOAD) && !ownVal && (tmoCnt == '0);

  // Reload outside LOAD and on every transfer, count down only while the owner is stalled.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tmoCnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (stateQ != LOAD || xfer) begin
      tmoCnt <= CNT_W'(TIMEOUT_CYC - 1);
    end else if (!ownVal && tmoCnt != '0) begin
      tmoCnt <= tmoCnt - 1'b1;
    end
  end

  // One-cycle abort pulse, coincident with the first IDLE cycle after the abort.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      timeoutQ <= 1'b0;
    end else begin
      timeoutQ <= tmoHit;
    end
  end

  assign oTimeout = timeoutQ;
`else
  assign tmoHit   = 1'b0;
  assign oTimeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (anyReq) stateD = LOAD;
      LOAD: begin
        if (xfer) begin
          stateD = WAIT;
        end else if (tmoHit) begin
          stateD = IDLE;
        end
      end
      WAIT: if (iTx_done) stateD = lastQ ? IDLE : LOAD;
      default: stateD = IDLE;
    endcase
  end

  // Owner, pointer and captured byte; the pointer only advances when a packet ends.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ownerQ <= '0;
      ptrQ   <= '0;
      dataQ  <= '0;
      lastQ  <= 1'b0;
      txValQ <= 1'b0;
    end else begin
      txValQ <= xfer;
      if (stateQ == IDLE && anyReq) begin
        ownerQ <= pickIdx;
      end
      if (xfer) begin
        dataQ <= ownData;
        lastQ <= iReq_Last[ownerQ];
      end
      if ((doneHit && lastQ) || tmoHit) begin
        ptrQ <= nextPtr;
      end
    end
  end

  // Outputs: grant follows the owner register, ready is gated by UART readiness in LOAD only.
  always_comb begin
    oBusy    = (stateQ != IDLE);
    oGrant   = '0;
    oReq_Rdy = '0;
    if (stateQ != IDLE) begin
      oGrant[ownerQ] = 1'b1;
    end
    if (stateQ == LOAD) begin
      oReq_Rdy[ownerQ] = iReq_Val[ownerQ] & iTx_Rdy;
    end
  end

  assign oTx_Val  = txValQ;
  assign oTx_Data = dataQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed requester traffic, a UART model that
// returns iTx_done 10 cycles after each start pulse, and a scoreboard of
// expected (byte, grant) pairs checked whenever oTx_Val pulses.

module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] g;
  } exp_t;

  logic             Clk;
  logic             Rst;
  logic [NR-1:0]    iReq_Val;
  logic [NR*DW-1:0] iReq_Data;
  logic [NR-1:0]    iReq_Last;
  logic [NR-1:0]    oReq_Rdy;
  logic [NR-1:0]    oGrant;
  logic             oTx_Val;
  logic [DW-1:0]    oTx_Data;
  logic             iTx_Rdy;
  logic             iTx_done;
  logic             oBusy;
  logic             oTimeout;

  logic          rdyEn;
  logic          uartBusy;
  logic [NR-1:0] xferSeen;
  int            checks;
  int            errors;
  int            tmoSeen;

  beat_t reqQ [NR][$];
  exp_t  expQ [$];

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_W     (DW),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .iReq_Val (iReq_Val),
    .iReq_Data(iReq_Data),
    .iReq_Last(iReq_Last),
    .oReq_Rdy (oReq_Rdy),
    .oGrant   (oGrant),
    .oTx_Val  (oTx_Val),
    .oTx_Data (oTx_Data),
    .iTx_Rdy  (iTx_Rdy),
    .iTx_done (iTx_done),
    .oBusy    (oBusy),
    .oTimeout (oTimeout)
  );

  assign iTx_Rdy = rdyEn & ~uartBusy;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic putReq(input int k, input logic [7:0] dat, input logic lst);
    reqQ[k].push_back('{d: dat, l: lst});
  endtask

  task automatic expectTx(input logic [7:0] dat, input logic [3:0] gnt);
    expQ.push_back('{d: dat, g: gnt});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((expQ.size() != 0 || oBusy || uartBusy) && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk(name, 32'(expQ.size()), 32'd0);
    chk({name, "_idle"}, 32'({oBusy, uartBusy}), 32'd0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Requester bank: present the head of each queue, pop once a transfer was seen.
  initial begin
    iReq_Val  = '0;
    iReq_Data = '0;
    iReq_Last = '0;
    forever begin
      @(posedge Clk);
      #2;
      for (int k = 0; k < NR; k++) begin
        if (xferSeen[k] && reqQ[k].size() > 0) void'(reqQ[k].pop_front());
        if (reqQ[k].size() > 0) begin
          iReq_Val[k]         = 1'b1;
          iReq_Data[k*DW +: DW] = reqQ[k][0].d;
          iReq_Last[k]        = reqQ[k][0].l;
        end else begin
          iReq_Val[k]         = 1'b0;
          iReq_Data[k*DW +: DW] = '0;
          iReq_Last[k]        = 1'b0;
        end
      end
    end
  end

  // UART model: busy for 10 cycles after each start pulse, then a one-cycle done.
  initial begin
    iTx_done = 1'b0;
    uartBusy = 1'b0;
    forever begin
      @(negedge Clk);
      if (oTx_Val) begin
        uartBusy = 1'b1;
        repeat (10) @(posedge Clk);
        #1 iTx_done = 1'b1;
        @(posedge Clk);
        #1 iTx_done = 1'b0;
        uartBusy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on every start pulse, plus per-cycle grant invariants.
  initial begin
    exp_t e;
    logic prevVal;
    prevVal  = 1'b0;
    tmoSeen  = 0;
    xferSeen = '0;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        prevVal  = 1'b0;
        xferSeen = '0;
      end else begin
        xferSeen = iReq_Val & oReq_Rdy;
        if (oTx_Val) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx: got data 0x%0h grant 0x%0h, nothing expected", oTx_Data, oGrant);
          end else begin
            e = expQ.pop_front();
            chk("tx_data", 32'(oTx_Data), 32'(e.d));
            chk("tx_grant", 32'(oGrant), 32'(e.g));
          end
          chk("tx_val_width", 32'({prevVal, oTx_Val}), 32'd1);
        end
        prevVal = oTx_Val;
        if (oReq_Rdy != '0) begin
          chk("rdy_only_owner", 32'(oReq_Rdy & ~oGrant), 32'd0);
        end
        if (oTimeout) begin
          tmoSeen++;
          chk("timeout_grant", 32'(oGrant), 32'd0);
        end
      end
    end
  end

  initial begin
    int n;
    int quiet;
    checks = 0;
    errors = 0;
    rdyEn  = 1'b1;
    Rst    = 1'b1;
    #2 Rst = 1'b0;
    #1 chk("reset_outputs", 32'({oGrant, oReq_Rdy, oTx_Val, oTx_Data, oBusy, oTimeout}), 32'd0);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;

    // Three-byte packet from req1.
    step();
    putReq(1, 8'hA1, 1'b0);
    putReq(1, 8'hA2, 1'b0);
    putReq(1, 8'hA3, 1'b1);
    expectTx(8'hA1, 4'b0010);
    expectTx(8'hA2, 4'b0010);
    expectTx(8'hA3, 4'b0010);
    drain("t1_drain");

    // Pointer now 2: req3 wins over req0.
    step();
    putReq(0, 8'h40, 1'b1);
    putReq(3, 8'h43, 1'b1);
    expectTx(8'h43, 4'b1000);
    expectTx(8'h40, 4'b0001);
    drain("t1_ptr_drain");

    // Fresh reset, then all four requesters at once.
    step();
    Rst = 1'b0;
    step();
    step();
    Rst = 1'b1;
    step();
    for (int k = 0; k < NR; k++) putReq(k, 8'(8'h10 + k), 1'b1);
    expectTx(8'h10, 4'b0001);
    expectTx(8'h11, 4'b0010);
    expectTx(8'h12, 4'b0100);
    expectTx(8'h13, 4'b1000);
    @(negedge Clk);
    chk("grant_latency_idle", 32'({oGrant, oBusy}), 32'd0);
    @(negedge Clk);
    chk("grant_latency_load", 32'(oGrant), 32'b0001);
    drain("t2_drain");
    step();
    putReq(0, 8'h14, 1'b1);
    expectTx(8'h14, 4'b0001);
    drain("t2_again_drain");

    // Pointer 1: req2 ahead of req0.
    step();
    putReq(0, 8'h20, 1'b1);
    putReq(2, 8'h22, 1'b1);
    expectTx(8'h22, 4'b0100);
    expectTx(8'h20, 4'b0001);
    drain("t3_drain");

    // Packet lock: req1 arrives mid-packet and waits.
    step();
    putReq(0, 8'hB0, 1'b0);
    putReq(0, 8'hB1, 1'b1);
    expectTx(8'hB0, 4'b0001);
    expectTx(8'hB1, 4'b0001);
    n = 0;
    while (!(iReq_Val[0] && oReq_Rdy[0]) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("t4_b0_accepted", 32'(iReq_Val[0] && oReq_Rdy[0]), 32'd1);
    step();
    putReq(1, 8'hC0, 1'b1);
    expectTx(8'hC0, 4'b0010);
    drain("t4_drain");

    // UART not ready for 20 cycles.
    step();
    rdyEn = 1'b0;
    putReq(3, 8'h35, 1'b1);
    expectTx(8'h35, 4'b1000);
    quiet = 0;
    repeat (20) begin
      @(negedge Clk);
      if (oReq_Rdy != '0 || oTx_Val) quiet++;
    end
    chk("t5_quiet", 32'(quiet), 32'd0);
    chk("t5_grant_held", 32'(oGrant), 32'b1000);
    step();
    rdyEn = 1'b1;
    @(negedge Clk);
    chk("t5_rdy_rise", 32'(oReq_Rdy), 32'b1000);
    @(negedge Clk);
    chk("t5_txval_next", 32'(oTx_Val), 32'd1);
    drain("t5_drain");

    // Move the pointer to 3, then reset while a byte is in the UART.
    step();
    putReq(2, 8'h62, 1'b1);
    expectTx(8'h62, 4'b0100);
    drain("t6_pre_drain");
    step();
    putReq(1, 8'h71, 1'b0);
    putReq(1, 8'h72, 1'b1);
    expectTx(8'h71, 4'b0010);
    expectTx(8'h72, 4'b0010);
    n = 0;
    while (expQ.size() != 1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("t6_first_byte_sent", 32'(expQ.size()), 32'd1);
    step();
    Rst = 1'b0;
    #1 chk("t6_reset_outputs", 32'({oGrant, oReq_Rdy, oTx_Val, oTx_Data, oBusy, oTimeout}), 32'd0);
    for (int k = 0; k < NR; k++) reqQ[k].delete();
    expQ.delete();
    step();
    step();
    Rst = 1'b1;
    n = 0;
    while (uartBusy && n < 100) begin
      @(negedge Clk);
      n++;
    end
    repeat (2) @(negedge Clk);
    chk("t6_stale_done_ignored", 32'({oBusy, oGrant, oTx_Val, uartBusy}), 32'd0);
    step();
    putReq(1, 8'h81, 1'b1);
    putReq(3, 8'h83, 1'b1);
    expectTx(8'h81, 4'b0010);
    expectTx(8'h83, 4'b1000);
    drain("t6_drain");

`ifdef UART_ARB_TIMEOUT_EN
    // Owner stalls mid-packet; grant is revoked and req1 goes next.
    step();
    putReq(0, 8'hD0, 1'b0);
    putReq(1, 8'hE1, 1'b1);
    expectTx(8'hD0, 4'b0001);
    expectTx(8'hE1, 4'b0010);
    drain("t7_drain");
    chk("t7_timeout_pulses", 32'(tmoSeen), 32'd1);
`else
    chk("no_timeout_pulses", 32'(tmoSeen), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
